// File: rtl/ffd_arb_pkg.sv
// ---------------------------------------------------------------------------
// ffd_arb_pkg
// Shared definitions for the flip-flop memory arbiter:
//   state_e - two-state access FSM encoding (ARB, ACCESS)
//   RID_W   - width of requester index fields (rid, winner, pointer)
//   MAX_REQ - largest supported requester count
//   onehot  - index to one-hot helper, MAX_REQ bits wide
// ---------------------------------------------------------------------------
package ffd_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int RID_W   = 3;
  localparam int MAX_REQ = 8;

  // One-hot encode a requester index; callers slice down to NUM_REQ bits.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [RID_W-1:0] idx);
    onehot = 8'h01 << idx;
  endfunction

endpackage

// File: rtl/ffd_rr_pick.sv
// ---------------------------------------------------------------------------
// ffd_rr_pick
// Combinational round-robin picker. Chooses the first set request bit at or
// after ptr, wrapping modulo NUM_REQ.
// Optional build macro FFD_ARB_PRIO0_EN: requester 0 wins whenever it is
// requesting, regardless of ptr.
// Ports:
//   req    in  [NUM_REQ-1:0] request vector
//   ptr    in  [RID_W-1:0]   search start index
//   winner out [RID_W-1:0]   chosen requester (0 when any=0)
//   any    out               at least one request set
// ---------------------------------------------------------------------------
module ffd_rr_pick
  import ffd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [RID_W-1:0]   ptr,
  output logic [RID_W-1:0]   winner,
  output logic               any
);

  int dist_s;
  int best_s;

  // Pick the set request at the smallest rotated distance from ptr.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    dist_s = 0;
    best_s = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        dist_s = i - int'(ptr);
        if (dist_s < 0) begin
          dist_s = dist_s + NUM_REQ;
        end else begin
          dist_s = dist_s;
        end
        if (dist_s < best_s) begin
          best_s = dist_s;
          winner = RID_W'(i);
          any    = 1'b1;
        end else begin
          best_s = best_s;
        end
      end else begin
        dist_s = dist_s;
      end
    end
`ifdef FFD_ARB_PRIO0_EN
    // Requester 0 overrides the rotation entirely.
    if (req[0]) begin
      winner = '0;
    end else begin
      winner = winner;
    end
`endif
  end

endmodule

// File: rtl/ffd_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ffd_mem_arbiter
// Round-robin arbiter sharing a DEPTH x WIDTH flip-flop register file between
// NUM_REQ requesters. Each granted command takes one ARB cycle and one ACCESS
// cycle, so one access completes every 2 cycles.
// Optional build macro FFD_ARB_PRIO0_EN: requester 0 has fixed top priority;
// the pointer then rotates among requesters 1..NUM_REQ-1 only.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   req    in   [NUM_REQ-1:0]        per-requester request
//   we     in   [NUM_REQ-1:0]        per-requester write enable
//   addr   in   [NUM_REQ*AW-1:0]     flattened addresses
//   wdata  in   [NUM_REQ*WIDTH-1:0]  flattened write data
//   gnt    out  [NUM_REQ-1:0]        one-hot grant, high during ACCESS
//   rvalid out                       one-cycle read-data-valid pulse
//   rid    out  [2:0]                requester owning rdata
//   rdata  out  [WIDTH-1:0]          read data, held until next read
// ---------------------------------------------------------------------------
module ffd_mem_arbiter
  import ffd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 8,
  parameter int AW      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       we,
  input  logic [NUM_REQ*AW-1:0]    addr,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rvalid,
  output logic [RID_W-1:0]         rid,
  output logic [WIDTH-1:0]         rdata
);

  state_e             state_q,   state_d;
  logic [RID_W-1:0]   ptr_q,     ptr_d;
  logic [RID_W-1:0]   win_q,     win_d;
  logic [NUM_REQ-1:0] gnt_q,     gnt_d;
  logic               we_l_q,    we_l_d;
  logic [AW-1:0]      addr_l_q,  addr_l_d;
  logic [WIDTH-1:0]   wdata_l_q, wdata_l_d;
  logic               rvalid_q,  rvalid_d;
  logic [RID_W-1:0]   rid_q,     rid_d;
  logic [WIDTH-1:0]   rdata_q,   rdata_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic [RID_W-1:0]   pick_winner_s;
  logic               pick_any_s;
  logic [MAX_REQ-1:0] pick_oh_s;
  logic               mem_we_s;

  ffd_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner_s),
    .any    (pick_any_s)
  );

  assign pick_oh_s = onehot(pick_winner_s);

  // Next-state and datapath control for the ARB/ACCESS sequence.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = '0;
    we_l_d    = we_l_q;
    addr_l_d  = addr_l_q;
    wdata_l_d = wdata_l_q;
    rvalid_d  = 1'b0;
    rid_d     = '0;
    rdata_d   = rdata_q;
    mem_we_s  = 1'b0;
    case (state_q)
      ARB: begin
        if (pick_any_s) begin
          state_d = ACCESS;
          gnt_d   = pick_oh_s[NUM_REQ-1:0];
          win_d   = pick_winner_s;
          // Latch the winner's command; later input changes are ignored.
          for (int i = 0; i < NUM_REQ; i++) begin
            if (RID_W'(i) == pick_winner_s) begin
              we_l_d    = we[i];
              addr_l_d  = addr[i*AW +: AW];
              wdata_l_d = wdata[i*WIDTH +: WIDTH];
            end else begin
              we_l_d = we_l_d;
            end
          end
        end else begin
          state_d = ARB;
        end
      end
      ACCESS: begin
        if (we_l_q) begin
          mem_we_s = 1'b1;
        end else begin
          rvalid_d = 1'b1;
          rid_d    = win_q;
          rdata_d  = mem_q[addr_l_q];
        end
`ifdef FFD_ARB_PRIO0_EN
        // Skip requester 0 in the rotation; it never needs the pointer.
        if (win_q >= RID_W'(NUM_REQ-1)) begin
          ptr_d = RID_W'(1);
        end else begin
          ptr_d = win_q + RID_W'(1);
        end
`else
        if (win_q == RID_W'(NUM_REQ-1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = win_q + RID_W'(1);
        end
`endif
        state_d = ARB;
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      we_l_q    <= 1'b0;
      addr_l_q  <= '0;
      wdata_l_q <= '0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      we_l_q    <= we_l_d;
      addr_l_q  <= addr_l_d;
      wdata_l_q <= wdata_l_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
    end
  end

  // Flip-flop storage array; reset wins over a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_s) begin
      mem_q[addr_l_q] <= wdata_l_q;
    end else begin
      mem_q[addr_l_q] <= mem_q[addr_l_q];
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign rid    = rid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_ffd_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ffd_mem_arbiter
// Directed bench for ffd_mem_arbiter (default build, NUM_REQ=4, DEPTH=8,
// WIDTH=8). Inputs change 1 time unit after a rising edge and outputs are
// sampled at the same point.
// ---------------------------------------------------------------------------
module tb_ffd_mem_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 8;
  localparam int WIDTH   = 8;
  localparam int AW      = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       we;
  logic [NUM_REQ*AW-1:0]    addr;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic                     rvalid;
  logic [2:0]               rid;
  logic [WIDTH-1:0]         rdata;

  int checks   = 0;
  int failures = 0;

  ffd_mem_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH),
    .AW      (AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rid    (rid),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input int i, input logic w, input logic [AW-1:0] a,
                     input logic [WIDTH-1:0] d);
    req[i]                = 1'b1;
    we[i]                 = w;
    addr[i*AW +: AW]      = a;
    wdata[i*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_gnt",    32'(gnt),    32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rid",    32'(rid),    32'h0);
    chk("rst_rdata",  32'(rdata),  32'h0);

    // Requester 2 writes 0xA5 to address 5, then requester 1 reads it back.
    cmd(2, 1'b1, 3'd5, 8'hA5);
    tick();
    chk("wr2_gnt", 32'(gnt), 32'h4);
    req = '0;
    tick();
    chk("wr2_gnt_drop",  32'(gnt),    32'h0);
    chk("wr2_no_rvalid", 32'(rvalid), 32'h0);
    cmd(1, 1'b0, 3'd5, 8'h00);
    tick();
    chk("rd1_gnt",        32'(gnt),    32'h2);
    chk("rd1_rvalid_lat", 32'(rvalid), 32'h0);
    req = '0;
    tick();
    chk("rd1_rvalid", 32'(rvalid), 32'h1);
    chk("rd1_rid",    32'(rid),    32'h1);
    chk("rd1_rdata",  32'(rdata),  32'hA5);
    chk("rd1_gnt_lo", 32'(gnt),    32'h0);
    tick();
    chk("rd1_pulse_end", 32'(rvalid), 32'h0);
    chk("rd1_rid_clr",   32'(rid),    32'h0);
    chk("rd1_hold",      32'(rdata),  32'hA5);

    // Requester 0 reads never-written address 3.
    cmd(0, 1'b0, 3'd3, 8'h00);
    tick();
    chk("rd0_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    chk("rd0_rvalid", 32'(rvalid), 32'h1);
    chk("rd0_rid",    32'(rid),    32'h0);
    chk("rd0_rdata",  32'(rdata),  32'h00);
    tick();
    chk("rd0_pulse_end", 32'(rvalid), 32'h0);

    // All four requesters held: grants rotate 0,1,2,3,0 every 2 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd(i, 1'b0, AW'(i), 8'h00);
    end
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("rr_gnt",    32'(gnt),    32'd1 << (s % 4));
      chk("rr_rv_lo",  32'(rvalid), 32'h0);
      tick();
      chk("rr_gnt_lo", 32'(gnt),    32'h0);
      chk("rr_rvalid", 32'(rvalid), 32'h1);
      chk("rr_rid",    32'(rid),    32'(s % 4));
    end
    req = '0;
    tick();
    chk("rr_idle_gnt", 32'(gnt), 32'h0);

    // Move ptr to 3 by serving requester 2, then req=1001 wraps 3 -> 0.
    cmd(2, 1'b0, 3'd0, 8'h00);
    tick();
    chk("wrap_pre_gnt", 32'(gnt), 32'h4);
    req = '0;
    tick();
    cmd(0, 1'b0, 3'd1, 8'h00);
    cmd(3, 1'b0, 3'd2, 8'h00);
    tick();
    chk("wrap_gnt3", 32'(gnt), 32'h8);
    req[3] = 1'b0;
    tick();
    chk("wrap_rid3", 32'(rid), 32'h3);
    tick();
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    req = '0;
    tick();
    chk("wrap_rid0", 32'(rid),    32'h0);
    chk("wrap_rv0",  32'(rvalid), 32'h1);

    // Reset during a write ACCESS discards the write and suppresses rvalid.
    cmd(1, 1'b1, 3'd7, 8'h3C);
    tick();
    chk("rstacc_gnt", 32'(gnt), 32'h2);
    req = '0;
    rst = 1'b1;
    tick();
    chk("rstacc_rvalid", 32'(rvalid), 32'h0);
    chk("rstacc_gnt_lo", 32'(gnt),    32'h0);
    rst = 1'b0;
    cmd(1, 1'b0, 3'd7, 8'h00);
    tick();
    chk("rstacc_rd_gnt", 32'(gnt), 32'h2);
    req = '0;
    tick();
    chk("rstacc_rd_rv",   32'(rvalid), 32'h1);
    chk("rstacc_rd_data", 32'(rdata),  32'h00);

    // Requester 2 changes addr/wdata during ACCESS; latched command is used.
    cmd(2, 1'b1, 3'd4, 8'h77);
    tick();
    chk("lat_gnt", 32'(gnt), 32'h4);
    addr[2*AW +: AW]        = 3'd6;
    wdata[2*WIDTH +: WIDTH] = 8'h11;
    req = '0;
    tick();
    cmd(2, 1'b0, 3'd4, 8'h00);
    tick();
    req = '0;
    tick();
    chk("lat_rd4_rv",   32'(rvalid), 32'h1);
    chk("lat_rd4_rid",  32'(rid),    32'h2);
    chk("lat_rd4_data", 32'(rdata),  32'h77);
    tick();
    chk("lat_hold", 32'(rdata), 32'h77);
    cmd(2, 1'b0, 3'd6, 8'h00);
    tick();
    req = '0;
    tick();
    chk("lat_rd6_data", 32'(rdata), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
